// File: rtl/sme_pkg.sv
// Shared constants, widths and FSM state type for the string match engine.
package sme_pkg;

  localparam int unsigned STR_MAX   = 32;
  localparam int unsigned PAT_MAX   = 8;
  localparam int unsigned STR_IDX_W = $clog2(STR_MAX);
  localparam int unsigned STR_LEN_W = $clog2(STR_MAX + 1);
  localparam int unsigned PAT_IDX_W = $clog2(PAT_MAX);
  localparam int unsigned PAT_LEN_W = $clog2(PAT_MAX + 1);

  localparam logic [7:0] CH_HAT    = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    LD_STR,
    LD_PAT,
    MATCH,
    OUTPUT
  } sme_state_t;

endpackage

// File: rtl/sme_window_cmp.sv
// Combinational compare of a pattern (up to PAT_MAX chars) against the
// stored string starting at pos. A leading '^' anchors the start to index 0
// or just after a space; a trailing '$' anchors the end to the string end or
// just before a space; '.' matches any char. The body must fit in the string.
module sme_window_cmp
  import sme_pkg::*;
(
  input  logic [STR_MAX*8-1:0] str_flat,
  input  logic [5:0]           str_len,
  input  logic [5:0]           pos,
  input  logic [PAT_MAX*8-1:0] pat_flat,
  input  logic [3:0]           pat_len,
  output logic                 hit_c
);

  logic [7:0] s_arr [STR_MAX];
  logic [7:0] p_arr [PAT_MAX];
  logic       has_hat;
  logic       has_dol;
  logic [3:0] body_len;
  logic [6:0] end_pos;
  logic       chars_ok;
  logic       start_ok;
  logic       end_ok;

  for (genvar i = 0; i < STR_MAX; i++) begin : g_s
    assign s_arr[i] = str_flat[i*8 +: 8];
  end
  for (genvar i = 0; i < PAT_MAX; i++) begin : g_p
    assign p_arr[i] = pat_flat[i*8 +: 8];
  end

  function automatic logic [7:0] str_at(input logic [6:0] idx);
    str_at = (idx < 7'(STR_MAX)) ? s_arr[idx[STR_IDX_W-1:0]] : 8'h00;
  endfunction

  // Decode anchors, compare the body chars and check both anchor conditions
  always_comb begin
    has_hat  = (pat_len != '0) && (p_arr[0] == CH_HAT);
    has_dol  = 1'b0;
    if (pat_len > PAT_LEN_W'(has_hat))
      has_dol = (p_arr[PAT_IDX_W'(pat_len - PAT_LEN_W'(1))] == CH_DOLLAR);
    body_len = pat_len - PAT_LEN_W'(has_hat) - PAT_LEN_W'(has_dol);
    end_pos  = 7'(pos) + 7'(body_len);
    chars_ok = 1'b1;
    for (int k = 0; k < PAT_MAX; k++) begin
      if ((PAT_LEN_W'(k) < body_len) &&
          (p_arr[PAT_IDX_W'(k + int'(has_hat))] != CH_DOT) &&
          (p_arr[PAT_IDX_W'(k + int'(has_hat))] != str_at(7'(pos) + 7'(k))))
        chars_ok = 1'b0;
    end
    start_ok = !has_hat || (pos == '0) || (str_at(7'(pos) - 7'd1) == CH_SPACE);
    end_ok   = !has_dol || (end_pos == 7'(str_len)) || (str_at(end_pos) == CH_SPACE);
    hit_c    = (end_pos <= 7'(str_len)) && chars_ok && start_ok && end_ok;
  end

endmodule

// File: rtl/string_match_engine.sv
// Byte-serial string match engine: stores a string (up to STR_MAX chars) and
// a pattern (up to PAT_MAX chars), then scans start positions in ascending
// order and reports the leftmost match with a one-cycle valid strobe.
// Build option SME_STAR_EN: '*' becomes a zero-or-more wildcard splitting the
// pattern into prefix and suffix; otherwise '*' is an ordinary char.
module string_match_engine
  import sme_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] chardata,
  input  logic       isstring,
  input  logic       ispattern,
  output logic       valid,
  output logic       match,
  output logic [4:0] match_index
);

  sme_state_t           state;
  logic [7:0]           str_mem [STR_MAX];
  logic [7:0]           pat_mem [PAT_MAX];
  logic [STR_LEN_W-1:0] str_len;
  logic [PAT_LEN_W-1:0] pat_len;
  logic [STR_LEN_W-1:0] pos;
  logic [STR_MAX*8-1:0] str_flat;
  logic [PAT_MAX*8-1:0] pat_flat;
  logic [PAT_MAX*8-1:0] pfx_flat;
  logic [PAT_LEN_W-1:0] pfx_len;
  logic                 pfx_hit;

  for (genvar i = 0; i < STR_MAX; i++) begin : g_str
    assign str_flat[i*8 +: 8] = str_mem[i];
  end
  for (genvar i = 0; i < PAT_MAX; i++) begin : g_pat
    assign pat_flat[i*8 +: 8] = pat_mem[i];
  end

`ifdef SME_STAR_EN
  logic                 has_star;
  logic [PAT_LEN_W-1:0] star_pos;
  logic [PAT_LEN_W-1:0] sfx_len;
  logic [PAT_LEN_W-1:0] pfx_body;
  logic [PAT_MAX*8-1:0] sfx_flat;
  logic                 sfx_hit;
  logic                 sfx_ok;
  logic                 pfx_found;
  logic [4:0]           pfx_idx;
  logic [6:0]           pfx_end;

  // Locate the first '*' and split the pattern into prefix and suffix
  always_comb begin
    has_star = 1'b0;
    star_pos = '0;
    for (int k = PAT_MAX - 1; k >= 0; k--) begin
      if ((PAT_LEN_W'(k) < pat_len) && (pat_mem[k] == CH_STAR)) begin
        has_star = 1'b1;
        star_pos = PAT_LEN_W'(k);
      end
    end
    pfx_flat = pat_flat;
    pfx_len  = has_star ? star_pos : pat_len;
    sfx_len  = has_star ? (pat_len - star_pos - PAT_LEN_W'(1)) : '0;
    sfx_flat = pat_flat >> {star_pos + PAT_LEN_W'(1), 3'b000};
    pfx_body = star_pos - PAT_LEN_W'((star_pos != '0) && (pat_mem[0] == CH_HAT));
  end

  // A suffix hit counts only at or after the end of the leftmost prefix hit
  assign sfx_ok = sfx_hit &&
                  (pfx_found ? (7'(pos) >= pfx_end) : (pfx_hit && (pfx_body == '0)));

  sme_window_cmp u_cmp_sfx (
    .str_flat (str_flat),
    .str_len  (str_len),
    .pos      (pos),
    .pat_flat (sfx_flat),
    .pat_len  (sfx_len),
    .hit_c    (sfx_hit)
  );
`else
  assign pfx_flat = pat_flat;
  assign pfx_len  = pat_len;
`endif

  sme_window_cmp u_cmp_pfx (
    .str_flat (str_flat),
    .str_len  (str_len),
    .pos      (pos),
    .pat_flat (pfx_flat),
    .pat_len  (pfx_len),
    .hit_c    (pfx_hit)
  );

  // Load FSM, position scan and registered result
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      str_len     <= '0;
      pat_len     <= '0;
      pos         <= '0;
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
`ifdef SME_STAR_EN
      pfx_found   <= 1'b0;
      pfx_idx     <= '0;
      pfx_end     <= '0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (isstring) begin
            str_mem[0] <= chardata;
            str_len    <= STR_LEN_W'(1);
            state      <= LD_STR;
          end else if (ispattern) begin
            pat_mem[0] <= chardata;
            pat_len    <= PAT_LEN_W'(1);
            state      <= LD_PAT;
          end
        end
        LD_STR: begin
          if (isstring) begin
            if (str_len < STR_LEN_W'(STR_MAX)) begin
              str_mem[STR_IDX_W'(str_len)] <= chardata;
              str_len <= str_len + STR_LEN_W'(1);
            end
          end else if (ispattern) begin
            pat_mem[0] <= chardata;
            pat_len    <= PAT_LEN_W'(1);
            state      <= LD_PAT;
          end else begin
            state <= IDLE;
          end
        end
        LD_PAT: begin
          if (ispattern) begin
            if (pat_len < PAT_LEN_W'(PAT_MAX)) begin
              pat_mem[PAT_IDX_W'(pat_len)] <= chardata;
              pat_len <= pat_len + PAT_LEN_W'(1);
            end
          end else begin
            pos   <= '0;
            state <= MATCH;
`ifdef SME_STAR_EN
            pfx_found <= 1'b0;
`endif
          end
        end
        MATCH: begin
`ifdef SME_STAR_EN
          if (has_star) begin
            if (sfx_ok) begin
              valid       <= 1'b1;
              match       <= 1'b1;
              match_index <= pfx_found ? pfx_idx : STR_IDX_W'(pos);
              state       <= OUTPUT;
            end else if (pos >= str_len) begin
              valid       <= 1'b1;
              match       <= 1'b0;
              match_index <= '0;
              state       <= OUTPUT;
            end else begin
              pos <= pos + STR_LEN_W'(1);
              if (!pfx_found && pfx_hit) begin
                pfx_found <= 1'b1;
                pfx_idx   <= STR_IDX_W'(pos);
                pfx_end   <= 7'(pos) + 7'(pfx_body);
              end
            end
          end else
`endif
          begin
            if (pfx_hit) begin
              valid       <= 1'b1;
              match       <= 1'b1;
              match_index <= STR_IDX_W'(pos);
              state       <= OUTPUT;
            end else if (pos >= str_len) begin
              valid       <= 1'b1;
              match       <= 1'b0;
              match_index <= '0;
              state       <= OUTPUT;
            end else begin
              pos <= pos + STR_LEN_W'(1);
            end
          end
        end
        OUTPUT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_string_match_engine.sv
// Scoreboard bench for string_match_engine: the driver queues the expected
// result of each pattern, the monitor pops and checks on every valid strobe.
module tb_string_match_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       valid;
  logic       match;
  logic [4:0] match_index;

  always #5 clk = ~clk;

  string_match_engine dut (
    .clk         (clk),
    .reset       (reset),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .valid       (valid),
    .match       (match),
    .match_index (match_index)
  );

  typedef struct {
    logic       m;
    logic [4:0] idx;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   t_fall  = 0;
  int   n_valid = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: strobe width, result contents and latency
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (prev_valid) begin
      checks++;
      if (valid) begin
        errors++;
        $display("FAIL valid_width: valid still high on second cycle, required one-cycle pulse");
      end
    end
    if (valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: valid with no pending pattern");
      end else begin
        e   = exp_q.pop_front();
        lat = cyc - t_fall;
        checks++;
        if (match !== e.m) begin
          errors++;
          $display("FAIL %s match: got %0b, required %0b", e.name, match, e.m);
        end
        checks++;
        if (match_index !== e.idx) begin
          errors++;
          $display("FAIL %s index: got %0d, required %0d", e.name, match_index, e.idx);
        end
        checks++;
        if (lat > 40 || lat < 1) begin
          errors++;
          $display("FAIL %s latency: got %0d cycles, required 1..40", e.name, lat);
        end
      end
    end
    prev_valid = valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_string(input string s);
    for (int i = 0; i < s.len(); i++) begin
      isstring = 1'b1;
      chardata = s[i];
      tick();
    end
    isstring = 1'b0;
  endtask

  task automatic run_pattern(input string p, input logic m, input logic [4:0] idx,
                             input string name);
    exp_t e;
    int   base;
    int   waited;
    e.m = m;
    e.idx = idx;
    e.name = name;
    exp_q.push_back(e);
    for (int i = 0; i < p.len(); i++) begin
      ispattern = 1'b1;
      chardata  = p[i];
      tick();
    end
    ispattern = 1'b0;
    chardata  = 8'h00;
    t_fall    = cyc;
    base      = n_valid;
    waited    = 0;
    while (n_valid == base && waited < 60) begin
      tick();
      waited++;
    end
    checks++;
    if (n_valid == base) begin
      errors++;
      $display("FAIL %s timeout: no valid within 60 cycles, required one", name);
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  task automatic check_val(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  initial begin
    int base;
    reset     = 1'b1;
    chardata  = 8'h00;
    isstring  = 1'b0;
    ispattern = 1'b0;
    repeat (3) tick();
    check_val("reset_valid", int'(valid), 0);
    check_val("reset_match", int'(match), 0);
    check_val("reset_index", int'(match_index), 0);
    reset = 1'b0;
    tick();

    load_string("THIS IS A BOOK");
    run_pattern("BOOK", 1'b1, 5'd10, "book");
    check_val("hold_match", int'(match), 1);
    check_val("hold_index", int'(match_index), 10);
    run_pattern("^IS", 1'b1, 5'd5, "hat_is");
    // "THIS" already ends just before a space, so the leftmost hit is at 2
    run_pattern("IS$", 1'b1, 5'd2, "is_dollar");
    run_pattern("H.S", 1'b1, 5'd1, "dot");
    run_pattern("^BO$", 1'b0, 5'd0, "hat_bo_dollar");
    run_pattern("^A$", 1'b1, 5'd8, "both_anchors");
    run_pattern("K$", 1'b1, 5'd13, "end_of_string");
    run_pattern("^T", 1'b1, 5'd0, "hat_start");
`ifdef SME_STAR_EN
    run_pattern("T*A", 1'b1, 5'd0, "star");
    run_pattern("IS*OOK", 1'b1, 5'd2, "star_long");
    run_pattern("K*A", 1'b0, 5'd0, "star_no_suffix");
`else
    run_pattern("T*A", 1'b0, 5'd0, "star_literal");
`endif

    load_string("abc");
    run_pattern("abcd", 1'b0, 5'd0, "too_long");
    run_pattern("abc", 1'b1, 5'd0, "exact_len");

    load_string("0123456789ABCDEFGHIJKLMNOPQRSTUV");
    run_pattern("UV$", 1'b1, 5'd30, "full_str_end");
    run_pattern("zz", 1'b0, 5'd0, "full_str_miss");

    // Abort a pattern load with reset: no strobe, outputs back to zero
    load_string("THIS IS A BOOK");
    ispattern = 1'b1;
    chardata  = "B";
    tick();
    chardata  = "O";
    tick();
    reset     = 1'b1;
    ispattern = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    base  = n_valid;
    repeat (50) tick();
    check_val("abort_no_valid", n_valid - base, 0);
    check_val("abort_match", int'(match), 0);
    check_val("abort_index", int'(match_index), 0);

    load_string("THIS IS A BOOK");
    run_pattern("BOOK", 1'b1, 5'd10, "after_abort");

    check_val("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
